// File: rtl/mem_pkg.sv
// Shared types for the byte-serial load/store controller: RISC-V width codes,
// controller states and the access-size decode.
package mem_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } funct3_e;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ACCESS,
        DRAIN,
        RESP
    } ctrl_state_e;

    // Illegal codes fall through to 4; they are rejected before any access.
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            LB, LBU: return 3'd1;
            LH, LHU: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled little-endian load word by width code.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = word_i;
        case (funct3_i)
            LB:      data_o = {{24{word_i[7]}}, word_i[7:0]};
            LH:      data_o = {{16{word_i[15]}}, word_i[15:0]};
            LBU:     data_o = {24'h000000, word_i[7:0]};
            LHU:     data_o = {16'h0000, word_i[15:0]};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_byte_ctrl.sv
// Load/store sequencer driving a byte-wide single-port memory one byte per
// cycle, little-endian, with alignment/range checking and load extension.
module mem_byte_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout
);

    ctrl_state_e state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] asm_q;
    logic        cap_vld_q;
    logic [1:0]  cap_lane_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [7:0]  mem_din_q;
    logic [2:0]  nbytes;
    logic [32:0] last_byte;
    logic        chk_err;
    logic [31:0] ext;

    // Decode of the latched request; 33-bit end address so a high base cannot wrap.
    always_comb begin
        nbytes    = size_bytes(f3_q);
        last_byte = {1'b0, addr_q} + 33'(nbytes) - 33'd1;
        chk_err   = 1'b0;
        case (f3_q)
            LB, LBU: chk_err = 1'b0;
            LH, LHU: chk_err = addr_q[0];
            LW:      chk_err = (addr_q[1:0] != 2'b00);
            default: chk_err = 1'b1;
        endcase
        if (last_byte > 33'(DEPTH - 1)) begin
            chk_err = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                err_d   = chk_err;
                cnt_d   = 2'd0;
                state_d = chk_err ? RESP : ACCESS;
            end
            ACCESS: begin
                if (cnt_q == 2'(nbytes - 3'd1)) begin
                    state_d = we_q ? RESP : DRAIN;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DRAIN:   state_d = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            err_q     <= 1'b0;
            cap_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            cap_vld_q <= (state_q == ACCESS) && !we_q;
        end
    end

    // Memory port is registered off the next state so byte k is on the pins
    // for the whole cycle in which the counter reads k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'h0;
            mem_din_q  <= 8'h00;
        end else if (state_d == ACCESS) begin
            mem_we_q   <= we_q;
            mem_addr_q <= addr_q + 32'(cnt_d);
            mem_din_q  <= wdata_q[{cnt_d, 3'b000} +: 8];
        end else begin
            mem_we_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
        cap_lane_q <= cnt_q;
        if (cap_vld_q) begin
            asm_q[{cap_lane_q, 3'b000} +: 8] <= mem_dout;
        end
    end

    load_extend u_load_extend (
        .word_i   (asm_q),
        .funct3_i (f3_q),
        .data_o   (ext)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !we_q) ? ext : 32'h0;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Randomized bench for mem_byte_ctrl with a byte-array memory and a reference
// model built from the access rules (sizes, alignment, range, extension, latency).
module tb_mem_byte_ctrl;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;

    logic [7:0]  mem [DEPTH];
    logic [7:0]  ref_mem [DEPTH];
    logic        poke_en = 1'b0;
    logic [9:0]  poke_addr = 10'h0;
    logic [7:0]  poke_data = 8'h0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_byte_ctrl #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    // Byte-wide memory with registered read; poke port preloads contents.
    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (mem_we && mem_addr < DEPTH) begin
            mem[mem_addr[9:0]] <= mem_din;
        end
        mem_dout <= (mem_addr < DEPTH) ? mem[mem_addr[9:0]] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = 10'(a);
        poke_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit is_err(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        n = size_of(f3);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (addr % n != 0) return 1'b1;
        if (longint'({32'h0, addr}) + n > DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    // Little-endian value of n bytes, then signed reinterpretation for B/H.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        longint v;
        int n;
        n = size_of(f3);
        v = 0;
        for (int i = 0; i < n; i++) begin
            v = v + longint'(ref_mem[addr + i]) * (longint'(1) << (8 * i));
        end
        if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * n - 1))) begin
            v = v - (longint'(1) << (8 * n));
        end
        return v[31:0];
    endfunction

    task automatic xfer(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input string tag);
        int          n;
        bit          err;
        int          lat_exp;
        int          lat;
        int          we_cnt;
        logic [31:0] rd_exp;
        n       = size_of(f3);
        err     = is_err(f3, addr);
        rd_exp  = (we || err) ? 32'h0 : model_load(f3, addr);
        lat_exp = err ? 1 : (we ? n + 1 : n + 2);
        @(negedge clk);
        check({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        check({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
        lat    = 0;
        we_cnt = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (mem_we) we_cnt++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(lat_exp));
        check({tag, ".err"}, 32'(resp_err), 32'(err));
        check({tag, ".rdata"}, resp_rdata, rd_exp);
        check({tag, ".we_cycles"}, 32'(we_cnt), (we && !err) ? 32'(n) : 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            req_valid  = 1'b1;
            req_we     = 1'($urandom);
            req_funct3 = 3'b010;
            req_addr   = 32'h0;
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
            check({tag, ".hold_err"}, 32'(resp_err), 32'(err));
            check({tag, ".hold_rdata"}, resp_rdata, rd_exp);
            check({tag, ".hold_we"}, 32'(mem_we), 32'd0);
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, ".done_valid"}, 32'(resp_valid), 32'd0);
        check({tag, ".done_ready"}, 32'(req_ready), 32'd1);
        if (we && !err) begin
            for (int i = 0; i < n; i++) begin
                ref_mem[addr + i] = wdata[8 * i +: 8];
            end
        end
        if (we && !err) begin
            for (int i = -1; i <= n; i++) begin
                if (int'(addr) + i >= 0 && int'(addr) + i < DEPTH) begin
                    check({tag, ".mem"}, 32'(mem[int'(addr) + i]), 32'(ref_mem[int'(addr) + i]));
                end
            end
        end
    endtask

    initial begin
        logic [2:0]  legal [5];
        logic [2:0]  f3;
        logic [31:0] a;
        int          r;
        int          n;
        legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        #1;
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_err", 32'(resp_err), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'h0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_addr", mem_addr, 32'h0);
        check("rst.mem_din", 32'(mem_din), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            poke(i, 8'($urandom));
        end
        @(negedge clk);
        rst_n = 1'b1;

        poke(16'h10, 8'h78); poke(16'h11, 8'h56); poke(16'h12, 8'h34); poke(16'h13, 8'h12);
        poke(3, 8'h80); poke(6, 8'h00); poke(7, 8'h80);
        xfer(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_0x10");
        check("lw_0x10.value", resp_rdata, 32'h0);
        xfer(1'b0, 3'b000, 32'h3, 32'h0, 0, "lb_0x3");
        xfer(1'b0, 3'b100, 32'h3, 32'h0, 0, "lbu_0x3");
        xfer(1'b0, 3'b001, 32'h6, 32'h0, 0, "lh_0x6");
        xfer(1'b0, 3'b101, 32'h6, 32'h0, 0, "lhu_0x6");
        check("ref.lw", model_load(3'b010, 32'h10), 32'h12345678);
        check("ref.lb", model_load(3'b000, 32'h3), 32'hFFFFFF80);
        check("ref.lh", model_load(3'b001, 32'h6), 32'hFFFF8000);
        xfer(1'b1, 3'b001, 32'h6, 32'hAABBCCDD, 0, "sh_0x6");
        check("sh_0x6.byte6", 32'(mem[6]), 32'hDD);
        check("sh_0x6.byte7", 32'(mem[7]), 32'hCC);
        xfer(1'b0, 3'b010, 32'h2, 32'h0, 0, "err_lw_0x2");
        xfer(1'b0, 3'b001, 32'h1, 32'h0, 0, "err_lh_0x1");
        xfer(1'b0, 3'b011, 32'h0, 32'h0, 0, "err_f3_011");
        xfer(1'b0, 3'b010, 32'h3FD, 32'h0, 0, "err_lw_0x3fd");
        xfer(1'b0, 3'b010, 32'h3FC, 32'h0, 0, "lw_0x3fc");
        xfer(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 3, "sw_hold");
        xfer(1'b1, 3'b000, 32'h45, 32'h000000A5, 0, "sb_0x45");

        for (int t = 0; t < 150; t++) begin
            r  = $urandom_range(0, 19);
            f3 = (r == 0) ? 3'b011 + 3'($urandom_range(0, 1)) * 3'b011 : legal[$urandom_range(0, 4)];
            if (f3 == 3'b110) f3 = 3'b111;
            n  = size_of(f3);
            if (r == 1)       a = $urandom_range(0, DEPTH - 1);
            else if (r == 2)  a = 32'(DEPTH - 4 + $urandom_range(0, 3));
            else if (r == 3)  a = 32'hFFFF_FFFC;
            else              a = 32'($urandom_range(0, DEPTH - 1)) & ~32'(n - 1);
            xfer(1'($urandom), f3, a, $urandom, $urandom_range(0, 2), "rand");
        end

        // Reset right after the second byte of a word store has been written.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h11223344;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.mem_we", 32'(mem_we), 32'd0);
        check("abort.req_ready", 32'(req_ready), 32'd1);
        check("abort.resp_valid", 32'(resp_valid), 32'd0);
        check("abort.mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_mem[32'h20] = 8'h44;
        ref_mem[32'h21] = 8'h33;
        for (int i = 32'h20; i <= 32'h23; i++) begin
            check("abort.mem", 32'(mem[i]), 32'(ref_mem[i]));
        end
        check("abort.byte20", 32'(mem[32'h20]), 32'h44);
        xfer(1'b0, 3'b010, 32'h20, 32'h0, 0, "after_abort_lw");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
